// File: rtl/rr_mux_arbiter_pkg.sv
// Shared definitions for the round-robin mux arbiter: FSM state encodings
// and the width helper used to size the burst counter.
package rr_mux_arbiter_pkg;

    // Arbiter ownership state. OWNk means source k won the most recent transfer.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    // Ceiling log2 for elaboration-time widths; returns at least 1 bit.
    function automatic int clog2_fn(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_2_1_bus.sv
// Plain 2:1 bus multiplexer: picks b when sel is high, a otherwise.
module mux_2_1_bus #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);

    // Pure combinational select feeding the output register.
    always_comb begin
        y = sel ? b : a;
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Two-source round-robin arbiter sharing one 2:1 datapath mux.
// A source keeps the grant for up to MAX_HOLD back-to-back transfers while
// the other side waits, then the grant rotates. The chosen word is captured
// in a single output register with valid/ready backpressure.
//
// Handshake: a word moves from a source when its valid and ready are both
// high at a rising edge; the output word moves when out_valid and out_ready
// are both high. Sources never make valid depend on ready and hold valid and
// data stable until accepted. Readys are combinational from out_ready, both
// valids and the registered state; both are low while the output stalls.
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    output logic             in1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             out_src
);

    localparam int                HOLD_W   = clog2_fn(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    arb_state_t        state;
    logic [HOLD_W-1:0] hold_cnt;
    logic              last;

    logic              load;
    logic              win_valid;
    logic              win_sel;
    logic              own_valid;
    logic              other_valid;
    logic              owner_idx;
    logic              owner_match;
    logic [WIDTH-1:0]  mux_out;

    // The output register may take a new word when empty or being drained.
    always_comb begin
        load = !out_valid || out_ready;
    end

    // Winner selection: owner keeps the grant until its burst budget is
    // spent, then yields if the other side is waiting; an idle arbiter
    // breaks ties against the most recently granted source.
    always_comb begin
        win_valid   = 1'b0;
        win_sel     = 1'b0;
        owner_idx   = (state == OWN1);
        own_valid   = owner_idx ? in1_valid : in0_valid;
        other_valid = owner_idx ? in0_valid : in1_valid;
        case (state)
            OWN0, OWN1: begin
                if (own_valid && (hold_cnt < HOLD_MAX)) begin
                    win_valid = 1'b1;
                    win_sel   = owner_idx;
                end else if (other_valid) begin
                    win_valid = 1'b1;
                    win_sel   = !owner_idx;
                end else if (own_valid) begin
                    win_valid = 1'b1;
                    win_sel   = owner_idx;
                end
            end
            default: begin
                if (in0_valid && in1_valid) begin
                    win_valid = 1'b1;
                    win_sel   = !last;
                end else if (in0_valid) begin
                    win_valid = 1'b1;
                    win_sel   = 1'b0;
                end else if (in1_valid) begin
                    win_valid = 1'b1;
                    win_sel   = 1'b1;
                end
            end
        endcase
        owner_match = ((state == OWN0) && !win_sel) || ((state == OWN1) && win_sel);
    end

    // Accept only from the winner, and only when the output can load.
    always_comb begin
        in0_ready = load && win_valid && !win_sel;
        in1_ready = load && win_valid && win_sel;
    end

    mux_2_1_bus #(
        .WIDTH (WIDTH)
    ) u_mux (
        .a   (in0_data),
        .b   (in1_data),
        .sel (win_sel),
        .y   (mux_out)
    );

    // Ownership FSM, burst counter and output register updated together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            last      <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 1'b0;
        end else if (load) begin
            if (win_valid) begin
                out_data  <= mux_out;
                out_src   <= win_sel;
                out_valid <= 1'b1;
                state     <= win_sel ? OWN1 : OWN0;
                last      <= win_sel;
                if (owner_match) begin
                    if (hold_cnt < HOLD_MAX) begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end else begin
                    hold_cnt <= HOLD_W'(1);
                end
            end else begin
                out_valid <= 1'b0;
                state     <= IDLE;
                hold_cnt  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: random and directed source traffic,
// a burst-level reference model feeding an expected queue, and a monitor that
// pops and compares on every output handshake.
module tb_rr_mux_arbiter;

    localparam int W  = 8;
    localparam int MH = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic         in0_valid = 1'b0;
    logic [W-1:0] in0_data  = '0;
    logic         in0_ready;
    logic         in1_valid = 1'b0;
    logic [W-1:0] in1_data  = '0;
    logic         in1_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready = 1'b0;
    logic         out_src;

    rr_mux_arbiter #(
        .WIDTH    (W),
        .MAX_HOLD (MH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0_valid (in0_valid),
        .in0_data  (in0_data),
        .in0_ready (in0_ready),
        .in1_valid (in1_valid),
        .in1_data  (in1_data),
        .in1_ready (in1_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .out_src   (out_src)
    );

    // ---------------- bookkeeping ----------------
    int checks   = 0;
    int failures = 0;

    logic [W:0]   exp_q[$];     // {src, data} in delivery order
    logic         src_log[$];
    logic [W-1:0] data_log[$];

    // Reference model: who holds the grant, how long the current burst is,
    // who was granted last, and whether the output register is occupied.
    int owner     = -1;
    int burst_len = 0;
    int last_src  = 1;
    bit model_ov  = 1'b0;

    bit acc0 = 1'b0;
    bit acc1 = 1'b0;
    int p0 = 0, p1 = 0, pr = 100;
    int ready_mode = -1;        // -1: random out_ready, else forced 0/1
    bit use_list = 1'b0;
    logic [W-1:0] list0[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        owner     = -1;
        burst_len = 0;
        last_src  = 1;
        model_ov  = 1'b0;
        exp_q.delete();
    endtask

    // Grant rule from the round-robin description, in terms of bursts.
    function automatic int pick(input bit v0, input bit v1);
        bit mine, theirs;
        if (owner < 0) begin
            if (v0 && v1) return 1 - last_src;
            if (v0) return 0;
            if (v1) return 1;
            return -1;
        end
        mine   = (owner == 0) ? v0 : v1;
        theirs = (owner == 0) ? v1 : v0;
        if (mine && burst_len < MH) return owner;
        if (theirs) return 1 - owner;
        if (mine) return owner;
        return -1;
    endfunction

    // ---------------- driver: one clock cycle ----------------
    task automatic step();
        bit   ld;
        int   w;
        logic [W-1:0] wd;
        @(negedge clk);
        if (acc0) in0_valid = 1'b0;
        if (acc1) in1_valid = 1'b0;
        if (!in0_valid) begin
            if (use_list) begin
                if (list0.size() > 0) begin
                    in0_valid = 1'b1;
                    in0_data  = list0.pop_front();
                end
            end else if ($urandom_range(0, 99) < p0) begin
                in0_valid = 1'b1;
                in0_data  = W'($urandom);
            end
        end
        if (!in1_valid && ($urandom_range(0, 99) < p1)) begin
            in1_valid = 1'b1;
            in1_data  = W'($urandom);
        end
        if (ready_mode < 0) out_ready = ($urandom_range(0, 99) < pr);
        else                out_ready = ready_mode[0];
        #1;
        check("out_valid", 32'(out_valid), 32'(model_ov));
        ld = !model_ov || out_ready;
        w  = ld ? pick(in0_valid, in1_valid) : -1;
        check("in0_ready", 32'(in0_ready), 32'(w == 0));
        check("in1_ready", 32'(in1_ready), 32'(w == 1));
        acc0 = in0_ready;
        acc1 = in1_ready;
        if (ld) begin
            if (w >= 0) begin
                wd = (w == 1) ? in1_data : in0_data;
                exp_q.push_back({w[0], wd});
                burst_len = (w == owner) ? ((burst_len < MH) ? burst_len + 1 : MH) : 1;
                owner     = w;
                last_src  = w;
                model_ov  = 1'b1;
            end else begin
                owner     = -1;
                burst_len = 0;
                model_ov  = 1'b0;
            end
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [W:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && out_valid && out_ready) begin
                src_log.push_back(out_src);
                data_log.push_back(out_data);
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 32'(out_valid), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", 32'(out_data), 32'(e[W-1:0]));
                    check("out_src", 32'(out_src), 32'(e[W]));
                end
            end
        end
    end

    // ---------------- stimulus sequence ----------------
    initial begin
        int rot_exp[8];
        logic [W-1:0] s;
        rot_exp = '{0, 0, 0, 0, 1, 1, 1, 1};

        // Reset with random inputs: outputs must sit at zero.
        #1 rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in0_valid = 1'($urandom); in0_data = W'($urandom);
            in1_valid = 1'($urandom); in1_data = W'($urandom);
            out_ready = 1'($urandom);
            #1;
            check("rst_out_valid", 32'(out_valid), 32'(0));
            check("rst_out_data", 32'(out_data), 32'(0));
            check("rst_out_src", 32'(out_src), 32'(0));
        end
        @(negedge clk);
        in0_valid = 1'b0; in1_valid = 1'b0; acc0 = 1'b0; acc1 = 1'b0;
        model_reset();
        rst_n = 1'b1;

        // Both always valid: first tie to in0, bursts of MH then rotate.
        src_log.delete(); data_log.delete();
        p0 = 100; p1 = 100; pr = 100; ready_mode = -1;
        for (int i = 0; i < 12; i++) step();
        check("rot_count_ge8", 32'(src_log.size() >= 8), 32'(1));
        for (int i = 0; i < 8 && i < src_log.size(); i++)
            check($sformatf("rot_src_%0d", i), 32'(src_log[i]), 32'(rot_exp[i]));

        // Async reset between edges mid-burst.
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'(0));
        check("arst_out_data", 32'(out_data), 32'(0));
        check("arst_out_src", 32'(out_src), 32'(0));
        in0_valid = 1'b0; in1_valid = 1'b0; acc0 = 1'b0; acc1 = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        src_log.delete(); data_log.delete();
        for (int i = 0; i < 4; i++) step();
        check("arst_first_src", 32'(src_log.size() > 0 ? src_log[0] : 1'b1), 32'(0));

        // Drain, then a single in0 stream 0x10..0x15 with no bubbles.
        p0 = 0; p1 = 0; ready_mode = 1;
        for (int i = 0; i < 4; i++) step();
        use_list = 1'b1;
        for (int i = 0; i < 6; i++) list0.push_back(W'(8'h10 + i));
        src_log.delete(); data_log.delete();
        for (int i = 0; i < 8; i++) step();
        check("stream_count", 32'(data_log.size()), 32'(6));
        for (int i = 0; i < 6 && i < data_log.size(); i++) begin
            s = W'(8'h10 + i);
            check($sformatf("stream_data_%0d", i), 32'(data_log[i]), 32'(s));
        end

        // Backpressure: 0xA5 held while out_ready is low for 3 cycles.
        list0.push_back(8'hA5);
        step();
        ready_mode = 0;
        list0.push_back(8'h5A);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_hold_data", 32'(out_data), 32'(8'hA5));
        end
        ready_mode = 1;
        step();
        check("bp_refill_data", 32'(out_data), 32'(8'hA5));
        step();
        check("bp_next_data", 32'(out_data), 32'(8'h5A));
        step();
        use_list = 1'b0;

        // Random traffic with mixed rates and backpressure.
        ready_mode = -1;
        for (int blk = 0; blk < 8; blk++) begin
            p0 = $urandom_range(20, 100);
            p1 = $urandom_range(20, 100);
            pr = $urandom_range(30, 100);
            for (int i = 0; i < 250; i++) step();
        end

        // Drain and confirm every accepted word was delivered.
        p0 = 0; p1 = 0; ready_mode = 1;
        for (int i = 0; i < 6; i++) step();
        check("final_queue_empty", 32'(exp_q.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #500000;
        $display("FAIL timeout actual=running required=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
